// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: state encoding,
// parity modes and a width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits needed to hold values 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and flags the last clock of each bit.
// clear holds the count at zero so the first bit of a frame is full length.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1250
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with elaboration-time width, parity, stop bits and baud.
//   state     | meaning
//   ST_IDLE   | line high, waiting for start
//   ST_START  | start bit (low) for one bit time
//   ST_DATA   | payload bits, LSB first
//   ST_PARITY | optional parity bit
//   ST_STOP   | STOP_BITS bit times of high line, done on the last tick
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int IW  = clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  uart_state_e          st_q, st_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_d, done_d;
  logic                 baud_clear, tick;

  assign baud_clear = (st_q == ST_IDLE);

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .tick    (tick)
  );

  always_comb begin
    st_d    = st_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = data_in;
          par_d   = (^data_in) ^ (PARITY == PAR_ODD);
          idx_d   = '0;
          st_d    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          idx_d = '0;
          st_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            idx_d = '0;
            st_d  = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          idx_d = '0;
          st_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        // idx counts stop bits here so two stop bits need no extra timer
        if (tick) begin
          if (idx_q == LAST_STOP) begin
            idx_d  = '0;
            done_d = 1'b1;
            st_d   = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase

    case (st_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      st_q    <= st_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= (st_d != ST_IDLE);
      done    <= done_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: four transmitter configurations run side by side, each
// with its own driver, expected-word queue and line-decoding monitor.
module tb_uart_tx_cfg;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input int inst, input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL inst%0d %s: actual %0d required %0d", inst, name, act, req);
    end
  endtask

  // Line level of every bit cell of a frame, from the framing rules alone.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int db,
                                             input int par, input int sb);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < db; i++) begin
      f[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (par == 1) f[1 + db] = ((ones % 2) == 1);
    if (par == 2) f[1 + db] = ((ones % 2) == 0);
    if (sb < 1) f[0] = 1'b1;
    return f;
  endfunction

  function automatic int cfg_baud(input int i);
    return (i == 0) ? 9600 : 115200;
  endfunction
  function automatic int cfg_db(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int DIV   = 12000000 / cfg_baud(g);
    localparam int DB    = cfg_db(g);
    localparam int PAR   = cfg_par(g);
    localparam int SB    = cfg_sb(g);
    localparam int NCELL = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FLEN  = NCELL * DIV;
    localparam logic [8:0] MASK = 9'((1 << DB) - 1);

    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] data  = '0;
    logic       tx, busy, done;
    logic [2:0] state;
    bit         go  = 1'b0;
    bit         fin = 1'b0;
    logic [8:0] exp_q[$];

    uart_tx_cfg #(
      .CLK_FREQ  (12000000),
      .BAUD      (cfg_baud(g)),
      .DATA_BITS (DB),
      .PARITY    (PAR),
      .STOP_BITS (SB)
    ) dut (
      .clock   (clock),
      .reset_n (rst_n),
      .start   (start),
      .data_in (data[DB-1:0]),
      .tx      (tx),
      .busy    (busy),
      .done    (done),
      .state   (state)
    );

    task automatic check_reset_vals(input string tag);
      check(g, {tag, "_tx"}, tx, 1);
      check(g, {tag, "_busy"}, busy, 0);
      check(g, {tag, "_done"}, done, 0);
      check(g, {tag, "_state"}, state, 0);
    endtask

    task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < FLEN + 10) begin
        @(negedge clock);
        k++;
      end
      check(g, "idle_wait_bounded", (k < FLEN + 10), 1);
    endtask

    task automatic send(input logic [8:0] d, input int hold);
      wait_idle();
      data  = d & MASK;
      start = 1'b1;
      exp_q.push_back(d & MASK);
      repeat (hold) @(negedge clock);
      start = 1'b0;
      data  = 9'($urandom);
    endtask

    task automatic send_random(input int n);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 5)) @(negedge clock);
        send(9'($urandom), $urandom_range(1, 3));
      end
    endtask

    task automatic run_frame(output bit ok);
      int bad[16];
      int c, early;
      logic [8:0] d;
      logic [15:0] lv;
      ok = 1'b0;
      for (int k = 0; k < 16; k++) bad[k] = 0;
      check(g, "frame_expected", (exp_q.size() > 0), 1);
      d = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
      lv = frame_bits(d, DB, PAR, SB);
      c = 0;
      early = 0;
      while (busy === 1'b1 && rst_n === 1'b1 && c < FLEN + 4) begin
        if (c < FLEN && tx !== lv[c / DIV]) bad[c / DIV]++;
        if (done !== 1'b0) early++;
        c++;
        @(negedge clock);
      end
      if (rst_n !== 1'b1) return;
      check(g, "busy_len", c, FLEN);
      check(g, "done_at_end", done, 1);
      check(g, "idle_state_at_end", state, 0);
      check(g, "idle_tx_at_end", tx, 1);
      check(g, "done_during_frame", early, 0);
      for (int k = 0; k < NCELL; k++)
        check(g, $sformatf("cell%0d_wrong_cycles_data%0h", k, d), bad[k], 0);
      ok = 1'b1;
    endtask

    initial begin : monitor
      bit skip, ok;
      skip = 1'b0;
      wait (go);
      forever begin
        if (!skip) @(negedge clock);
        skip = 1'b0;
        if (rst_n === 1'b1 && busy === 1'b1) begin
          run_frame(ok);
          if (ok) begin
            @(negedge clock);
            check(g, "done_one_cycle", done, 0);
            skip = 1'b1;
          end
        end
      end
    end

    initial begin : driver
      logic [8:0] d1, d2;
      int k;
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_async");
      repeat (10) @(negedge clock);
      check_reset_vals("rst_held");
      rst_n = 1'b1;
      repeat (10) @(negedge clock);
      check_reset_vals("rst_released");
      go = 1'b1;
      @(negedge clock);

      case (g)
        0: begin
          send(9'h055, 2);
          send(9'h0FF, 1);
          repeat (DIV * 5) @(negedge clock);
          data  = 9'h000;
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
          check(g, "ignore_start_busy", busy, 1);
        end
        1: begin
          send(9'h0A5, 1);
          send(9'h001, 3);
          wait_idle();
          d1    = 9'($urandom) & MASK;
          data  = d1;
          start = 1'b1;
          exp_q.push_back(d1);
          @(negedge clock);
          start = 1'b0;
          repeat (DIV * 4 + DIV / 2) @(negedge clock);
          check(g, "abort_in_data_state", state, 2);
          #2 rst_n = 1'b0;
          #1 check_reset_vals("abort_async");
          repeat (3) @(negedge clock);
          rst_n = 1'b1;
          send(9'h041, 1);
          send_random(4);
        end
        2: begin
          send(9'h0A5, 1);
          send(9'h001, 2);
          send_random(4);
        end
        default: begin
          send(9'h041, 1);
          wait_idle();
          d1    = 9'($urandom) & MASK;
          d2    = 9'($urandom) & MASK;
          data  = d1;
          start = 1'b1;
          exp_q.push_back(d1);
          @(negedge clock);
          check(g, "b2b_first_busy", busy, 1);
          data = d2;
          exp_q.push_back(d2);
          k = 0;
          while (done !== 1'b1 && k < FLEN + 10) begin
            @(negedge clock);
            k++;
          end
          check(g, "b2b_gap_done", done, 1);
          check(g, "b2b_gap_tx", tx, 1);
          check(g, "b2b_gap_busy", busy, 0);
          check(g, "b2b_gap_state", state, 0);
          @(negedge clock);
          check(g, "b2b_restart_busy", busy, 1);
          check(g, "b2b_restart_tx", tx, 0);
          start = 1'b0;
          data  = 9'($urandom);
          send_random(3);
        end
      endcase

      wait_idle();
      repeat (3 * DIV) @(negedge clock);
      check(g, "no_leftover_expect", exp_q.size(), 0);
      check(g, "final_busy", busy, 0);
      fin = 1'b1;
    end
  end

  initial begin : supervisor
    int cyc;
    bit all_fin;
    cyc = 0;
    all_fin = 1'b0;
    while (!all_fin && cyc < 95000) begin
      @(negedge clock);
      cyc++;
      all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin && g_inst[3].fin;
    end
    check(-1, "all_drivers_finished", all_fin, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. The block serialises one DATA_BITS-wide word per start request. Data width, parity mode, stop-bit count and baud divisor are all set at elaboration. It sits between the 12 MHz system-clock logic and the board TX pin, and adds a one-cycle done pulse alongside the existing start/busy handshake.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD (integer divide) clocks per bit; DIV < 2 is an elaboration error
DATA_BITS, 8, payload width, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd; other values are an elaboration error
STOP_BITS, 1, 1 or 2

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  transmit request, level-sampled in IDLE only
data_in  input  DATA_BITS  payload, captured on the cycle start is accepted
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress
done  output  1  single-cycle pulse at frame completion
state  output  3  current FSM state, debug/monitor visibility

Behaviour:
- Reset: while reset_n is low, asynchronously force tx=1, busy=0, done=0, state=IDLE, baud counter=0 and bit index=0.
- Reset mid-frame aborts the frame immediately; tx returns high with no partial stop bit.
- FSM states: IDLE(0), START(1), DATA(2), PARITY(3), STOP(4).
- IDLE: tx=1, busy=0.
  - If start=1 at a clock edge: latch data_in into shift_reg, compute the parity bit from the latched value, clear the counter, go to START.
  - From that edge: busy=1 and tx=0. Latency from start to the start bit on the line is 1 clock.
- Every non-IDLE state lasts exactly DIV clocks. The baud counter runs 0..DIV-1, and tick=1 when it equals DIV-1.
- START: tx=0. On tick, go to DATA with bit index=0.
- DATA: tx=shift_reg[0] (LSB first).
  - On tick, shift right and increment the index.
  - After bit DATA_BITS-1, go to PARITY if PARITY!=0, otherwise go to STOP.
- PARITY: even mode sends the XOR of all data bits; odd mode sends its inverse. On tick, go to STOP.
- STOP: tx=1 for STOP_BITS*DIV clocks.
  - On the final tick, go to IDLE, pulse done=1 for exactly one clock, and drop busy in that same cycle.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks, measured from the first busy=1 cycle to the first busy=0 cycle.
- start while busy=1 is ignored; there is no queueing.
- data_in changes during a frame have no effect.
- start held high continuously gives back-to-back frames separated by exactly 1 idle clock with tx=1. done and the IDLE state coincide in that clock, and the next frame is accepted at the end of it.
- tx is driven from a register, so it is glitch-free.
- Counter width = clog2(DIV). Bit-index width = clog2(DATA_BITS+1). No overflow is possible within the legal ranges.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants ST_IDLE..ST_STOP, 3 bits;
  - parity mode constants PAR_NONE, PAR_EVEN, PAR_ODD;
  - a clog2 helper function.
- Sub-module uart_baud_tick:
  - parameters DIV;
  - ports clock, reset_n, clear, tick;
  - a free-running counter restarted by clear.
- uart_tx_cfg instantiates one uart_baud_tick and contains the FSM, shift register and parity logic.

Test Plan:
All scenarios use defaults unless stated: DIV=1250, bit time 104.167 us.
1. Reset check: hold reset_n=0 for 10 clocks, including an assertion mid-cycle between edges -> tx=1, busy=0, done=0 and state=0 immediately. Release the reset, wait 10 clocks -> the outputs stay the same.
2. 8N1 frame, data_in=0x55, start pulsed 2 clocks:
   - tx sampled mid-bit reads 0, 1,0,1,0,1,0,1,0, 1 (start, LSB first, stop);
   - busy stays high for exactly 12500 clocks;
   - done pulses once;
   - only one frame is sent despite the 2-clock start.
3. Parity, data_in=0xA5, run twice:
   - PARITY=1 -> parity bit 0, frame 11 bits = 13750 clocks;
   - PARITY=2 -> parity bit 1.
   - Repeat with 0x01: even -> 1, odd -> 0.
4. Ignore rules: launch 0xFF, then mid-frame pulse start and change data_in to 0x00 -> the frame still carries 0xFF, no second frame follows, and busy falls after 12500 clocks.
5. Abort and back-to-back, in two parts:
   - Assert reset_n=0 during DATA bit 3 -> tx=1 and busy=0 asynchronously; after release, a new 0x41 frame sends correctly.
   - Hold start=1 across two frames -> exactly 1 idle clock between stop and the next start bit, with done high in that clock.
6. DATA_BITS=7, STOP_BITS=2, PARITY=0, data_in=0x41 -> tx reads 0, 1,0,0,0,0,0,1, 1,1, busy lasts 12500 clocks; CLK_FREQ=12000000 with BAUD=115200 -> DIV=104 and each bit lasts 104 clocks.
